// File: rtl/rs485_poll_sched_pkg.sv
// Shared types and constants for the RS-485 master poll scheduler.
// Holds the FSM state encoding, poll header and counter widths.
package rs485_pkg;

   localparam int unsigned ID_W   = 3;
   localparam int unsigned US_W   = 8;
   localparam int unsigned BCNT_W = 4;

   localparam logic [4:0] POLL_HDR = 5'b10100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_PRE,
      S_SEND,
      S_POST,
      S_WAIT,
      S_NEXT
   } state_e;

   // Poll byte carries the slave ID in its low bits.
   function automatic logic [7:0] poll_byte(input logic [ID_W-1:0] id);
      return {POLL_HDR, id};
   endfunction

endpackage

// File: rtl/rs485_poll_sched_us_timer.sv
// Loadable microsecond down-counter shared by every timed scheduler phase.
// Decrements on pulse_i only; zero_c flags an exhausted count.
module us_timer
   import rs485_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            pulse_i,
   input  logic            load_i,
   input  logic [US_W-1:0] load_val_i,
   output logic            zero_c
);

   logic [US_W-1:0] cnt_q;

   // A load in the same cycle as a strobe wins; the strobe is not counted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (pulse_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - US_W'(1);
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/rs485_poll_sched.sv
// RS-485 master frame scheduler: sync pulse, then poll/response per enabled slave.
// Optional RS485_RETRY_EN re-polls a silent slave once before flagging its timeout.
module rs485_poll_sched
   import rs485_pkg::*;
#(
   parameter int unsigned N_SLAVE   = 4,
   parameter int unsigned SYN_US    = 10,
   parameter int unsigned GUARD_US  = 5,
   parameter int unsigned TMO_US    = 200,
   parameter int unsigned RSP_BYTES = 4
) (
   input  logic               clk_sys,
   input  logic               rst,
   input  logic               pulse_us,
   input  logic               start,
   input  logic [N_SLAVE-1:0] slave_en,
   output logic               tx_ctrl,
   output logic               tx_syn,
   output logic               tx_req,
   output logic [7:0]         tx_data,
   input  logic               tx_done,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   output logic               rsp_valid,
   output logic [7:0]         rsp_data,
   output logic [ID_W-1:0]    rsp_id,
   output logic               busy,
   output logic [N_SLAVE-1:0] tmo_mask,
   output logic               frame_done
);

   state_e               state_q;
   logic [N_SLAVE-1:0]   pend_q;
   logic [N_SLAVE-1:0]   cur_oh_q;
   logic [ID_W-1:0]      cur_id_q;
   logic [BCNT_W-1:0]    byte_cnt_q;
   logic                 tx_ctrl_q;
   logic                 tx_syn_q;
   logic                 tx_req_q;
   logic [7:0]           tx_data_q;
   logic                 rsp_valid_q;
   logic [7:0]           rsp_data_q;
   logic                 busy_q;
   logic [N_SLAVE-1:0]   tmo_mask_q;
   logic                 frame_done_q;

   logic                 found_c;
   logic [ID_W-1:0]      next_id_c;
   logic [N_SLAVE-1:0]   next_oh_c;
   logic                 tmr_load_c;
   logic [US_W-1:0]      tmr_val_c;
   logic                 tmr_zero_c;
   logic                 tmr_exp_c;
   logic                 retry_now_c;
   logic                 last_byte_c;

`ifdef RS485_RETRY_EN
   logic                 retry_q;
   assign retry_now_c = !retry_q;
`else
   assign retry_now_c = 1'b0;
`endif

   assign tmr_exp_c   = pulse_us && tmr_zero_c;
   assign last_byte_c = (byte_cnt_q == BCNT_W'(RSP_BYTES - 1));

   // Lowest still-pending ID; served IDs are removed from pend_q.
   always_comb begin
      found_c   = 1'b0;
      next_id_c = '0;
      next_oh_c = '0;
      for (int i = int'(N_SLAVE) - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            found_c   = 1'b1;
            next_id_c = ID_W'(i);
            next_oh_c = N_SLAVE'(1) << i;
         end
      end
   end

   // Timer is loaded on every entry into a timed phase and on each response byte.
   always_comb begin
      tmr_load_c = 1'b0;
      tmr_val_c  = '0;
      case (state_q)
         S_IDLE: begin
            if (start && (slave_en != '0)) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = US_W'(SYN_US - 1);
            end
         end
         S_NEXT: begin
            if (found_c) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = US_W'(GUARD_US - 1);
            end
         end
         S_SEND: begin
            if (tx_done) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = US_W'(GUARD_US - 1);
            end
         end
         S_POST: begin
            if (tmr_exp_c) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = US_W'(TMO_US - 1);
            end
         end
         S_WAIT: begin
            if (rx_valid) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = US_W'(TMO_US - 1);
            end else if (tmr_exp_c && retry_now_c) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = US_W'(GUARD_US - 1);
            end
         end
         default: begin
         end
      endcase
   end

   us_timer u_timer (
      .clk_i      (clk_sys),
      .rst_i      (rst),
      .pulse_i    (pulse_us),
      .load_i     (tmr_load_c),
      .load_val_i (tmr_val_c),
      .zero_c     (tmr_zero_c)
   );

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pend_q       <= '0;
         cur_oh_q     <= '0;
         cur_id_q     <= '0;
         byte_cnt_q   <= '0;
         tx_ctrl_q    <= 1'b0;
         tx_syn_q     <= 1'b0;
         tx_req_q     <= 1'b0;
         tx_data_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         busy_q       <= 1'b0;
         tmo_mask_q   <= '0;
         frame_done_q <= 1'b0;
`ifdef RS485_RETRY_EN
         retry_q      <= 1'b0;
`endif
      end else begin
         rsp_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pend_q     <= slave_en;
                  tmo_mask_q <= '0;
                  if (slave_en != '0) begin
                     busy_q    <= 1'b1;
                     tx_ctrl_q <= 1'b1;
                     tx_syn_q  <= 1'b1;
                     state_q   <= S_SYNC;
                  end else begin
                     frame_done_q <= 1'b1;
                  end
               end
            end
            S_SYNC: begin
               if (tmr_exp_c) begin
                  tx_syn_q <= 1'b0;
                  state_q  <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (found_c) begin
                  pend_q     <= pend_q & ~next_oh_c;
                  cur_oh_q   <= next_oh_c;
                  cur_id_q   <= next_id_c;
                  tx_data_q  <= poll_byte(next_id_c);
                  byte_cnt_q <= '0;
                  tx_ctrl_q  <= 1'b1;
`ifdef RS485_RETRY_EN
                  retry_q    <= 1'b0;
`endif
                  state_q    <= S_PRE;
               end else begin
                  frame_done_q <= 1'b1;
                  busy_q       <= 1'b0;
                  tx_ctrl_q    <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            S_PRE: begin
               if (tmr_exp_c) begin
                  tx_req_q <= 1'b1;
                  state_q  <= S_SEND;
               end
            end
            S_SEND: begin
               if (tx_done) begin
                  tx_req_q <= 1'b0;
                  state_q  <= S_POST;
               end
            end
            S_POST: begin
               if (tmr_exp_c) begin
                  tx_ctrl_q <= 1'b0;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A byte arriving on the final strobe beats the timeout.
               if (rx_valid) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= rx_data;
                  byte_cnt_q  <= byte_cnt_q + BCNT_W'(1);
                  if (last_byte_c) begin
                     state_q <= S_NEXT;
                  end
               end else if (tmr_exp_c) begin
                  if (retry_now_c) begin
`ifdef RS485_RETRY_EN
                     retry_q    <= 1'b1;
`endif
                     byte_cnt_q <= '0;
                     tx_ctrl_q  <= 1'b1;
                     state_q    <= S_PRE;
                  end else begin
                     tmo_mask_q <= tmo_mask_q | cur_oh_q;
                     state_q    <= S_NEXT;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_ctrl    = tx_ctrl_q;
   assign tx_syn     = tx_syn_q;
   assign tx_req     = tx_req_q;
   assign tx_data    = tx_data_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_id     = cur_id_q;
   assign busy       = busy_q;
   assign tmo_mask   = tmo_mask_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rs485_poll_sched.sv
// Directed bench for rs485_poll_sched with a serializer/slave model.
// 1 us is modelled as 4 clock cycles.
module tb_rs485_poll_sched;

   localparam int TMO = 200;
   localparam int SER_CYC = 20;

   logic       clk, rst, pulse_us, start, tx_done, rx_valid;
   logic [3:0] slave_en;
   logic [7:0] rx_data;
   logic       tx_ctrl, tx_syn, tx_req, rsp_valid, busy, frame_done;
   logic [7:0] tx_data, rsp_data;
   logic [2:0] rsp_id;
   logic [3:0] tmo_mask;

   int total = 0;
   int bad = 0;

   int cyc, us_div, ser_cnt, rsp_left, rsp_k, gap, wstb, fd_cnt, last_rx_cyc;
   bit req_seen, in_wait, prev_ctrl, coincide, fire;
   logic [2:0] cur_ans;
   int ans_n [8];
   logic [7:0] tx_log [$];
   logic [2:0] rid_log [$];
   logic [7:0] rdat_log [$];

   rs485_poll_sched #(
      .N_SLAVE(4), .SYN_US(10), .GUARD_US(5), .TMO_US(200), .RSP_BYTES(4)
   ) dut (
      .clk_sys(clk), .rst(rst), .pulse_us(pulse_us), .start(start),
      .slave_en(slave_en), .tx_ctrl(tx_ctrl), .tx_syn(tx_syn), .tx_req(tx_req),
      .tx_data(tx_data), .tx_done(tx_done), .rx_valid(rx_valid), .rx_data(rx_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
      .tmo_mask(tmo_mask), .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Environment: us strobe, serializer, slave responder and output logging.
   initial begin
      pulse_us = 0; tx_done = 0; rx_valid = 0; rx_data = '0;
      cyc = 0; us_div = 0; ser_cnt = -1; rsp_left = 0; rsp_k = 0; gap = 0;
      wstb = 0; fd_cnt = 0; last_rx_cyc = -1; req_seen = 0; in_wait = 0;
      prev_ctrl = 0; coincide = 0; cur_ans = '0;
      foreach (ans_n[i]) ans_n[i] = 0;
      forever begin
         @(posedge clk); #2;
         cyc++;
         us_div = (us_div + 1) % 4;
         pulse_us = (us_div == 0);
         tx_done = 0;
         rx_valid = 0;
         if (rst) begin
            ser_cnt = -1; rsp_left = 0; req_seen = 0; in_wait = 0; prev_ctrl = 0;
         end else begin
            if (rsp_valid) begin
               rid_log.push_back(rsp_id);
               rdat_log.push_back(rsp_data);
            end
            if (frame_done) fd_cnt++;
            if (tx_req && !req_seen) begin
               tx_log.push_back(tx_data);
               req_seen = 1;
               ser_cnt = SER_CYC;
               cur_ans = tx_data[2:0];
            end
            if (!tx_req) req_seen = 0;
            if (ser_cnt == 0) begin
               tx_done = 1;
               ser_cnt = -1;
               rsp_left = ans_n[cur_ans];
               rsp_k = 0;
               gap = 6;
            end else if (ser_cnt > 0) begin
               ser_cnt--;
            end
            if (prev_ctrl && !tx_ctrl) begin
               in_wait = 1;
               wstb = 0;
            end
            if (tx_ctrl) in_wait = 0;
            prev_ctrl = tx_ctrl;
            if (in_wait && pulse_us) wstb++;
            if (in_wait && rsp_left > 0) begin
               if (coincide && rsp_k == 0) begin
                  fire = pulse_us && (wstb == TMO);
               end else begin
                  fire = (gap == 0);
                  if (gap > 0) gap--;
               end
               if (fire) begin
                  rx_valid = 1;
                  rx_data = {2'b11, cur_ans, 3'(rsp_k)};
                  rsp_k++;
                  rsp_left--;
                  gap = 6;
                  last_rx_cyc = cyc;
               end
            end
         end
      end
   end

   task automatic set_answers(input int n0, input int n1, input int n2, input int n3);
      ans_n[0] = n0; ans_n[1] = n1; ans_n[2] = n2; ans_n[3] = n3;
   endtask

   task automatic run_frame(input logic [3:0] en, input int poke_at,
                            output bit done, output int mask_cyc, output int ctrl_hi);
      bit fell;
      tx_log.delete(); rid_log.delete(); rdat_log.delete();
      fd_cnt = 0; done = 0; mask_cyc = -1; ctrl_hi = 0; fell = 0;
      slave_en = en;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      for (int i = 0; i < 4000; i++) begin
         start = (i == poke_at);
         if (i == poke_at) slave_en = 4'hF;
         if (tx_log.size() > 0 && !tx_ctrl) fell = 1;
         else if (fell && tx_ctrl) ctrl_hi++;
         if (tmo_mask != '0 && mask_cyc < 0) mask_cyc = cyc + 1;
         if (frame_done) begin
            done = 1;
            break;
         end
         @(posedge clk); #1;
      end
      start = 0;
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; start = 0; slave_en = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({tx_ctrl, tx_syn, tx_req, busy, rsp_valid, frame_done} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {tx_ctrl, tx_syn, tx_req, busy, rsp_valid, frame_done});
      end
      total++;
      if ({tx_data, rsp_data, rsp_id, tmo_mask} !== 23'b0) begin
         bad++;
         $display("FAIL reset_data: got tx=%h rsp=%h id=%0d mask=%b want zeros",
                  tx_data, rsp_data, rsp_id, tmo_mask);
      end
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_two_slaves();
      bit done; int mc, ch;
      logic [2:0] eid;
      set_answers(4, 4, 4, 4);
      run_frame(4'b0101, 30, done, mc, ch);
      total++;
      if (!done) begin bad++; $display("FAIL two_done: frame_done never seen"); end
      total++;
      if (tx_log.size() != 2) begin
         bad++; $display("FAIL two_txcount: got %0d want 2", tx_log.size());
      end
      total++;
      if (tx_log[0] !== 8'hA0) begin bad++; $display("FAIL two_tx0: got %h want a0", tx_log[0]); end
      total++;
      if (tx_log[1] !== 8'hA2) begin bad++; $display("FAIL two_tx1: got %h want a2", tx_log[1]); end
      total++;
      if (rid_log.size() != 8) begin
         bad++; $display("FAIL two_rspcount: got %0d want 8", rid_log.size());
      end
      for (int k = 0; k < 8; k++) begin
         eid = (k < 4) ? 3'd0 : 3'd2;
         total++;
         if (rid_log[k] !== eid || rdat_log[k] !== {2'b11, eid, 3'(k % 4)}) begin
            bad++;
            $display("FAIL two_rsp%0d: got id=%0d data=%h want id=%0d data=%h",
                     k, rid_log[k], rdat_log[k], eid, {2'b11, eid, 3'(k % 4)});
         end
      end
      total++;
      if (tmo_mask !== 4'b0000) begin bad++; $display("FAIL two_mask: got %b want 0000", tmo_mask); end
      total++;
      if (fd_cnt != 1) begin bad++; $display("FAIL two_fdcount: got %0d want 1", fd_cnt); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL two_busy: got %b want 0", busy); end
   endtask

   task automatic test_no_answer();
      bit done; int mc, ch;
      set_answers(4, 0, 4, 4);
      run_frame(4'b0010, -1, done, mc, ch);
      total++;
      if (!done) begin bad++; $display("FAIL noans_done: frame_done never seen"); end
      total++;
      if (tmo_mask !== 4'b0010) begin bad++; $display("FAIL noans_mask: got %b want 0010", tmo_mask); end
      total++;
      if (rid_log.size() != 0) begin
         bad++; $display("FAIL noans_rsp: got %0d want 0", rid_log.size());
      end
`ifdef RS485_RETRY_EN
      total++;
      if (tx_log.size() != 2 || tx_log[0] !== 8'hA1 || tx_log[1] !== 8'hA1) begin
         bad++; $display("FAIL noans_retry_tx: got %0d polls want 2 x a1", tx_log.size());
      end
`else
      total++;
      if (tx_log.size() != 1 || tx_log[0] !== 8'hA1) begin
         bad++; $display("FAIL noans_tx: got %0d polls want 1 x a1", tx_log.size());
      end
      total++;
      if (ch != 0) begin bad++; $display("FAIL noans_txctrl: got %0d high cycles want 0", ch); end
`endif
   endtask

   task automatic test_partial();
      bit done; int mc, ch, delta;
      set_answers(4, 4, 4, 2);
      run_frame(4'b1000, -1, done, mc, ch);
      total++;
      if (!done) begin bad++; $display("FAIL part_done: frame_done never seen"); end
`ifdef RS485_RETRY_EN
      total++;
      if (rid_log.size() != 4) begin bad++; $display("FAIL part_rsp: got %0d want 4", rid_log.size()); end
`else
      total++;
      if (rid_log.size() != 2) begin bad++; $display("FAIL part_rsp: got %0d want 2", rid_log.size()); end
`endif
      total++;
      if (rdat_log[0] !== 8'hD8 || rdat_log[1] !== 8'hD9) begin
         bad++; $display("FAIL part_data: got %h %h want d8 d9", rdat_log[0], rdat_log[1]);
      end
      total++;
      if (tmo_mask !== 4'b1000) begin bad++; $display("FAIL part_mask: got %b want 1000", tmo_mask); end
      delta = mc - last_rx_cyc;
      total++;
      if (delta < 798 || delta > 801) begin
         bad++; $display("FAIL part_tmo_time: got %0d cycles want 798..801", delta);
      end
   endtask

   task automatic test_empty_mask();
      slave_en = 4'b0000;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      total++;
      if (frame_done !== 1'b1) begin bad++; $display("FAIL empty_fd: got %b want 1", frame_done); end
      total++;
      if (tx_ctrl !== 1'b0 || tx_syn !== 1'b0) begin
         bad++; $display("FAIL empty_bus: got ctrl=%b syn=%b want 0 0", tx_ctrl, tx_syn);
      end
      total++;
      if (tmo_mask !== 4'b0000) begin bad++; $display("FAIL empty_mask: got %b want 0000", tmo_mask); end
      @(posedge clk); #1;
      total++;
      if ({frame_done, busy, tx_syn, tx_ctrl} !== 4'b0000) begin
         bad++; $display("FAIL empty_after: got %b want 0000", {frame_done, busy, tx_syn, tx_ctrl});
      end
   endtask

   task automatic test_reset_mid_send();
      bit found, done; int mc, ch;
      set_answers(0, 4, 4, 4);
      slave_en = 4'b0011;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      found = 0;
      for (int i = 0; i < 4000; i++) begin
         if (tx_req && tx_data == 8'hA1 && tmo_mask == 4'b0001) begin
            found = 1;
            break;
         end
         @(posedge clk); #1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL rstsend_reach: SEND to id 1 with mask 0001 never seen"); end
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      total++;
      if ({tx_ctrl, tx_syn, tx_req, busy, rsp_valid, frame_done} !== 6'b0) begin
         bad++; $display("FAIL rstsend_ctrl: got %b want 000000",
                         {tx_ctrl, tx_syn, tx_req, busy, rsp_valid, frame_done});
      end
      total++;
      if ({tx_data, rsp_id, tmo_mask} !== 15'b0) begin
         bad++; $display("FAIL rstsend_data: got tx=%h id=%0d mask=%b want zeros", tx_data, rsp_id, tmo_mask);
      end
      run_frame(4'b0100, -1, done, mc, ch);
      total++;
      if (!done || tx_log.size() != 1 || tx_log[0] !== 8'hA2) begin
         bad++; $display("FAIL rstsend_clean_tx: got done=%b polls=%0d want 1 x a2", done, tx_log.size());
      end
      total++;
      if (rid_log.size() != 4 || tmo_mask !== 4'b0000 || fd_cnt != 1) begin
         bad++; $display("FAIL rstsend_clean_rsp: got rsp=%0d mask=%b fd=%0d want 4 0000 1",
                         rid_log.size(), tmo_mask, fd_cnt);
      end
   endtask

   task automatic test_coincide();
      bit done; int mc, ch;
      set_answers(4, 4, 4, 4);
      coincide = 1;
      run_frame(4'b0001, -1, done, mc, ch);
      coincide = 0;
      total++;
      if (!done) begin bad++; $display("FAIL coin_done: frame_done never seen"); end
      total++;
      if (rid_log.size() != 4) begin bad++; $display("FAIL coin_rsp: got %0d want 4", rid_log.size()); end
      total++;
      if (rdat_log[0] !== 8'hC0) begin bad++; $display("FAIL coin_data: got %h want c0", rdat_log[0]); end
      total++;
      if (tmo_mask !== 4'b0000) begin bad++; $display("FAIL coin_mask: got %b want 0000", tmo_mask); end
   endtask

   initial begin
      rst = 1; start = 0; slave_en = '0;
      test_reset();
      test_two_slaves();
      test_no_answer();
      test_partial();
      test_empty_mask();
      test_reset_mid_send();
      test_coincide();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rs485_poll_sched.md
# rs485_poll_sched

Master-side scheduler for the shared RS-485 link. It owns the half-duplex bus and sequences one frame: a sync pulse on `tx_syn`, then a one-byte poll to each enabled slave in ascending-ID order. After each poll it turns the bus around and collects a fixed-length response, or times out. It sits between the clock/reset top (`clk_sys`, `pulse_us`) and the byte serializer/deserializer that drive and sample the line.

## Interface
Parameters:
- `N_SLAVE`, 4: number of slave IDs (1..8); ID width is 3.
- `SYN_US`, 10: sync pulse width in µs.
- `GUARD_US`, 5: driver-enable guard before first TX bit and after last TX bit, in µs.
- `TMO_US`, 200: response timeout in µs, counted from the end of turnaround.
- `RSP_BYTES`, 4: response length in bytes (1..15).

Ports:
- `clk_sys` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `pulse_us` in 1: one-cycle strobe every 1 µs.
- `start` in 1: request one frame; sampled only in IDLE.
- `slave_en` in N_SLAVE: per-ID poll enable, latched at frame start.
- `tx_ctrl` out 1: RS-485 driver enable.
- `tx_syn` out 1: sync line.
- `tx_req` out 1: byte-send request to serializer.
- `tx_data` out 8: poll byte, `{5'b10100, id}`.
- `tx_done` in 1: one-cycle strobe when the serializer has shifted out the last stop bit.
- `rx_valid` in 1: one-cycle strobe with a received byte.
- `rx_data` in 8: received byte.
- `rsp_valid` out 1: one-cycle strobe with `rsp_data`.
- `rsp_data` out 8: forwarded response byte.
- `rsp_id` out 3: ID of the slave currently being served.
- `busy` out 1: frame in progress.
- `tmo_mask` out N_SLAVE: slaves that timed out in the last frame.
- `frame_done` out 1: one-cycle strobe at frame end.

## Operation
- Reset values: all outputs 0; state IDLE.
- FSM states: IDLE, SYNC, PRE, SEND, POST, WAIT, NEXT.
- IDLE + `start`:
  - latch `slave_en`; clear `tmo_mask`; set `busy`; go to SYNC.
  - If the latched mask is 0, skip SYNC: `frame_done` pulses on the next cycle and the FSM returns to IDLE.
- SYNC: `tx_ctrl`=1, `tx_syn`=1 for SYN_US `pulse_us` strobes, then go to NEXT.
- NEXT:
  - Select the lowest enabled ID greater than the last served ID and go to PRE.
  - If none remains, pulse `frame_done`, clear `busy`, go to IDLE.
- PRE: `tx_ctrl`=1 for GUARD_US strobes, then go to SEND.
- SEND: `tx_req`=1 with stable `tx_data` until `tx_done`. `tx_req` drops in the cycle after `tx_done`; go to POST.
- POST: keep `tx_ctrl`=1 for GUARD_US strobes, then drop `tx_ctrl`, load the timeout counter and go to WAIT.
- WAIT:
  - Each `rx_valid` is forwarded: `rsp_valid`/`rsp_data` are registered, one cycle after input; `rsp_id` holds the current ID.
  - Each `rx_valid` also increments the byte count and reloads the timeout counter.
  - After RSP_BYTES bytes, go to NEXT.
  - On timeout, set `tmo_mask[id]` and go to NEXT.
  - Bytes received in any state other than WAIT are dropped.
- `tx_ctrl` is never 1 in WAIT. This is the bus-contention invariant.
- Reset mid-frame: the synchronous reset returns to IDLE on the next edge and drops `tx_ctrl` immediately. The partial `tmo_mask` is cleared.

## Timing
- µs counters decrement only on `pulse_us`. A phase of K µs lasts between K and K+1 µs; phase entry is not aligned to `pulse_us`.
- A count reaching 0 exits the state on the same cycle as that strobe.
- Timeout of exactly TMO_US strobes with no `rx_valid`: the timeout fires. If `rx_valid` and the last strobe coincide, the byte wins and the counter reloads.
- Byte counter width is 4 bits; the count is compared against RSP_BYTES and never wraps.
- `start` while `busy` is ignored, not queued.

## Configuration
- `RS485_RETRY_EN` defined: a slave that times out is re-polled once, via PRE→SEND, before its `tmo_mask` bit is set. A retry flag is cleared at each new ID.
- Undefined: no retry; the timeout sets the mask bit immediately.

## Structure
- Package `rs485_pkg`:
  - FSM state enum.
  - `POLL_HDR` = 5'b10100.
  - ID width constant.
  - µs counter width, 8 bits, sized so that TMO_US ≤ 255.
- Sub-module `us_timer`: a loadable µs down-counter with a `pulse_us` enable and a `zero` flag. It is shared by SYNC, PRE, POST and WAIT.

## Test plan
- `slave_en`=4'b0101, slaves answer 4 bytes each → `tx_data` 0xA0 then 0xA2; 8 `rsp_valid` with `rsp_id` 0 then 2; `tmo_mask`=0; one `frame_done`.
- `slave_en`=4'b0010, no answer → `tx_ctrl` 0 through the whole WAIT; `tmo_mask`=4'b0010 after about 200 µs. With `RS485_RETRY_EN`, 0xA1 is sent twice.
- Slave sends 2 bytes then stops → 2 `rsp_valid`, timeout 200 µs after the 2nd byte, mask bit set.
- `slave_en`=0 with `start` → `frame_done` 1 cycle later; `tx_syn` and `tx_ctrl` stay 0.
- `rst` asserted during SEND → next cycle all outputs 0 and state IDLE; a new `start` runs a clean frame.
- `rx_valid` coinciding with the final timeout strobe → byte forwarded, no timeout.
